// File: rtl/partial_load_unit.sv
// Purpose : RV32 load lane unit. Takes one LB/LH/LW/LBU/LHU request, issues a single
//           word read to data memory and returns the sign/zero-extended lane.
// Latency : READ_LATENCY+2 cycles from the accept cycle to LoadValid; faults take 1 cycle.
// Backpr. : single outstanding request; ReqReady only in IDLE, and the result is held
//           in RESP until LoadValid && LoadReady.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   LoadReq / ReqReady         request handshake (Instruction, MemAddress captured at accept)
//   MemRdEn / MemRdAddr        one-cycle word-read strobe and word address to data memory
//   MemRdData                  read data, valid READ_LATENCY cycles after MemRdEn
//   LoadData / LoadFault       extended result, or fault flag (data forced to zero)
//   LoadValid / LoadReady      response handshake to writeback
module partial_load_unit #(
  parameter int READ_LATENCY = 1,  // 1..4
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              LoadReq,
  output logic              ReqReady,
  input  logic [31:0]       Instruction,
  input  logic [ADDR_W-1:0] MemAddress,
  output logic              MemRdEn,
  output logic [ADDR_W-3:0] MemRdAddr,
  input  logic [31:0]       MemRdData,
  output logic [31:0]       LoadData,
  output logic              LoadFault,
  output logic              LoadValid,
  input  logic              LoadReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // funct3 encodings of the supported loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Two bits cover the full 1..4 latency range (counter runs READ_LATENCY-1 down to 0).
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         data_q, data_d;
  logic                fault_q, fault_d;

  // Only funct3 is meaningful here; the rest of the instruction is decoded elsewhere.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instruction[31:15], Instruction[11:0]};

  // ---------------------------------------------------------------------------
  // Fault classification of the request being captured. The result is stored
  // alongside the captured funct3/offset, so the decision always refers to the
  // values the request was accepted with.
  // ---------------------------------------------------------------------------
  logic [2:0] req_funct3;
  logic [1:0] req_off;
  logic       req_illegal;
  logic       req_misaligned;
  logic       req_fault;

  assign req_funct3 = Instruction[14:12];
  assign req_off    = MemAddress[1:0];

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_LB, F3_LBU:  req_misaligned = 1'b0;
      F3_LH, F3_LHU:  req_misaligned = req_off[0];
      F3_LW:          req_misaligned = (req_off != 2'b00);
      default:        req_illegal    = 1'b1;  // 011, 110, 111
    endcase
  end

  assign req_fault = req_illegal | req_misaligned;

  // ---------------------------------------------------------------------------
  // Lane extraction from the returned word using the captured offset/funct3.
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] extracted;

  always_comb begin
    byte_lane = MemRdData[7:0];
    case (off_q)
      2'd0: byte_lane = MemRdData[7:0];
      2'd1: byte_lane = MemRdData[15:8];
      2'd2: byte_lane = MemRdData[23:16];
      2'd3: byte_lane = MemRdData[31:24];
      default: byte_lane = MemRdData[7:0];
    endcase
  end

  assign half_lane = off_q[1] ? MemRdData[31:16] : MemRdData[15:0];

  always_comb begin
    extracted = MemRdData;
    case (funct3_q)
      F3_LB:   extracted = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  extracted = {24'd0, byte_lane};
      F3_LH:   extracted = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  extracted = {16'd0, half_lane};
      F3_LW:   extracted = MemRdData;
      default: extracted = 32'd0;  // unreachable: illegal encodings never issue a read
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    waddr_d  = waddr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fault_d  = fault_q;

    case (state_q)
      IDLE: begin
        if (LoadReq) begin
          funct3_d = req_funct3;
          off_d    = req_off;
          waddr_d  = MemAddress[ADDR_W-1:2];
          if (req_fault) begin
            // Faulting loads never touch memory and answer on the next cycle.
            fault_d = 1'b1;
            data_d  = 32'd0;
            state_d = RESP;
          end else begin
            fault_d = 1'b0;
            state_d = READ;
          end
        end
      end

      READ: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == 2'd0) begin
          data_d  = extracted;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      RESP: begin
        // Returning to IDLE (not accepting directly) keeps a one-cycle gap so a
        // new request is never taken in the handshake cycle.
        if (LoadReady) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. A reset in any state drops the in-flight request; any data
  // still arriving from memory is never sampled because WAIT is left behind.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      waddr_q  <= '0;
      cnt_q    <= 2'd0;
      data_q   <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      waddr_q  <= waddr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state, so they are glitch-free and
  // stable for the whole cycle.
  // ---------------------------------------------------------------------------
  assign ReqReady  = (state_q == IDLE);
  assign MemRdEn   = (state_q == READ);
  assign MemRdAddr = waddr_q;
  assign LoadValid = (state_q == RESP);
  assign LoadData  = data_q;
  assign LoadFault = fault_q;

endmodule

// File: tb/tb_partial_load_unit.sv
module tb_partial_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A: READ_LATENCY = 1 ----------------
  logic        rstn1, LoadReq1, ReqReady1, MemRdEn1, LoadFault1, LoadValid1, LoadReady1;
  logic [31:0] Instr1, MemRdData1, LoadData1;
  logic [9:0]  Addr1;
  logic [7:0]  MemRdAddr1;

  partial_load_unit #(.READ_LATENCY(1), .ADDR_W(10)) dut1 (
    .clk(clk), .rstn(rstn1), .LoadReq(LoadReq1), .ReqReady(ReqReady1),
    .Instruction(Instr1), .MemAddress(Addr1), .MemRdEn(MemRdEn1), .MemRdAddr(MemRdAddr1),
    .MemRdData(MemRdData1), .LoadData(LoadData1), .LoadFault(LoadFault1),
    .LoadValid(LoadValid1), .LoadReady(LoadReady1)
  );

  // ---------------- instance B: READ_LATENCY = 3 ----------------
  logic        rstn3, LoadReq3, ReqReady3, MemRdEn3, LoadFault3, LoadValid3, LoadReady3;
  logic [31:0] Instr3, MemRdData3, LoadData3;
  logic [9:0]  Addr3;
  logic [7:0]  MemRdAddr3;

  partial_load_unit #(.READ_LATENCY(3), .ADDR_W(10)) dut3 (
    .clk(clk), .rstn(rstn3), .LoadReq(LoadReq3), .ReqReady(ReqReady3),
    .Instruction(Instr3), .MemAddress(Addr3), .MemRdEn(MemRdEn3), .MemRdAddr(MemRdAddr3),
    .MemRdData(MemRdData3), .LoadData(LoadData3), .LoadFault(LoadFault3),
    .LoadValid(LoadValid3), .LoadReady(LoadReady3)
  );

  // ---------------- memory model: shared contents, per-instance read pipes ----------------
  logic [31:0] mem [256];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  always @(posedge clk) rd1 <= MemRdEn1 ? mem[MemRdAddr1] : 32'hDEADBEEF;
  always @(posedge clk) begin
    p3[0] <= MemRdEn3 ? mem[MemRdAddr3] : 32'hDEADBEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign MemRdData1 = rd1;
  assign MemRdData3 = p3[2];

  // ---------------- scoreboard for instance A ----------------
  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [7:0]  waddr;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor samples mid-cycle; the stimulus drives 1 time unit after the rising edge.
  logic        prev_v = 1'b0;
  logic        hold   = 1'b0;
  logic [31:0] hold_d;
  logic        hold_f;

  always @(negedge clk) begin
    if (rstn1 === 1'b1) begin
      if (MemRdEn1 === 1'b1) begin
        chk("rden_sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          chk("rden_not_fault", {31'd0, sb[0].fault}, 32'd0);
          chk("rd_addr", {24'd0, MemRdAddr1}, {24'd0, sb[0].waddr});
        end
      end
      if (LoadValid1 === 1'b1) begin
        chk("valid_sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          if (!prev_v)
            chk("latency", 32'(cyc - sb[0].acc), sb[0].fault ? 32'd1 : 32'd3);
          if (hold) begin
            chk("hold_data", LoadData1, hold_d);
            chk("hold_fault", {31'd0, LoadFault1}, {31'd0, hold_f});
          end
          if (LoadReady1 === 1'b1) begin
            chk("data", LoadData1, sb[0].data);
            chk("fault", {31'd0, LoadFault1}, {31'd0, sb[0].fault});
            void'(sb.pop_front());
            hold = 1'b0;
          end else begin
            hold   = 1'b1;
            hold_d = LoadData1;
            hold_f = LoadFault1;
          end
        end
      end else begin
        hold = 1'b0;
      end
      prev_v = LoadValid1;
    end
  end

  // Issue one request to instance A once it is ready; inputs are scrambled afterwards.
  task automatic issue1(input logic [2:0] f3, input logic [9:0] a,
                        input logic [31:0] ed, input logic ef, output int acc);
    int   n = 0;
    exp_t e;
    while (ReqReady1 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("req_ready_wait", {31'd0, ReqReady1}, 32'd1);
    Instr1   = {17'($urandom), f3, 5'($urandom), 7'b0000011};
    Addr1    = a;
    LoadReq1 = 1'b1;
    e.data = ed; e.fault = ef; e.waddr = a[9:2]; e.acc = cyc;
    sb.push_back(e);
    acc = cyc;
    tick();
    LoadReq1 = 1'b0;
    Instr1   = $urandom;
    Addr1    = 10'($urandom);
  endtask

  task automatic drain1();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin tick(); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Issue to instance B and measure the cycles from the accept cycle to LoadValid.
  task automatic issue3(input logic [2:0] f3, input logic [9:0] a,
                        output int lat, output logic [31:0] d, output logic f);
    int n = 0;
    int acc;
    while (ReqReady3 !== 1'b1 && n < 50) begin tick(); n++; end
    Instr3   = {17'($urandom), f3, 5'($urandom), 7'b0000011};
    Addr3    = a;
    LoadReq3 = 1'b1;
    acc      = cyc;
    tick();
    LoadReq3 = 1'b0;
    Addr3    = 10'($urandom);
    lat = -1; d = 32'hX; f = 1'bx; n = 0;
    while (lat < 0 && n < 20) begin
      if (LoadValid3 === 1'b1) begin
        lat = cyc - acc;
        d   = LoadData3;
        f   = LoadFault3;
      end else begin
        tick();
        n++;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2, lat, nv;
    logic [31:0] d;
    logic f;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF7F01;
    mem[1] = 32'h8001ABCD;
    mem[2] = 32'h12345678;
    mem[3] = 32'hCAFEF00D;

    rstn1 = 1'b0; LoadReq1 = 1'b0; Instr1 = 32'h0; Addr1 = 10'h0; LoadReady1 = 1'b1;
    rstn3 = 1'b0; LoadReq3 = 1'b0; Instr3 = 32'h0; Addr3 = 10'h0; LoadReady3 = 1'b1;
    repeat (3) tick();

    // reset values
    chk("rst_reqready", {31'd0, ReqReady1}, 32'd1);
    chk("rst_rden", {31'd0, MemRdEn1}, 32'd0);
    chk("rst_rdaddr", {24'd0, MemRdAddr1}, 32'd0);
    chk("rst_data", LoadData1, 32'd0);
    chk("rst_fault", {31'd0, LoadFault1}, 32'd0);
    chk("rst_valid", {31'd0, LoadValid1}, 32'd0);
    rstn1 = 1'b1; rstn3 = 1'b1;
    tick();

    // LB / LBU sweep
    issue1(3'b000, 10'h000, 32'h00000001, 1'b0, a0);
    issue1(3'b000, 10'h001, 32'h0000007F, 1'b0, a0);
    issue1(3'b000, 10'h002, 32'hFFFFFFFF, 1'b0, a0);
    issue1(3'b000, 10'h003, 32'hFFFFFF80, 1'b0, a0);
    issue1(3'b100, 10'h003, 32'h00000080, 1'b0, a0);
    issue1(3'b100, 10'h001, 32'h0000007F, 1'b0, a0);
    // LH / LHU / LW
    issue1(3'b001, 10'h004, 32'hFFFFABCD, 1'b0, a0);
    issue1(3'b001, 10'h006, 32'hFFFF8001, 1'b0, a0);
    issue1(3'b101, 10'h006, 32'h00008001, 1'b0, a0);
    issue1(3'b010, 10'h004, 32'h8001ABCD, 1'b0, a0);
    // faults
    issue1(3'b001, 10'h003, 32'h0, 1'b1, a0);
    issue1(3'b010, 10'h002, 32'h0, 1'b1, a0);
    issue1(3'b011, 10'h000, 32'h0, 1'b1, a0);
    issue1(3'b110, 10'h008, 32'h0, 1'b1, a0);
    issue1(3'b101, 10'h005, 32'h0, 1'b1, a0);
    drain1();

    // backpressure
    LoadReady1 = 1'b0;
    issue1(3'b010, 10'h008, 32'h12345678, 1'b0, a0);
    nv = 0;
    while (LoadValid1 !== 1'b1 && nv < 20) begin tick(); nv++; end
    chk("bp_valid_seen", {31'd0, LoadValid1}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_reqready_low", {31'd0, ReqReady1}, 32'd0);
      chk("bp_valid_high", {31'd0, LoadValid1}, 32'd1);
      LoadReq1 = (i % 2 == 0);
      Addr1    = 10'($urandom);
      tick();
    end
    LoadReq1   = 1'b0;
    LoadReady1 = 1'b1;
    tick();
    chk("bp_reqready_after", {31'd0, ReqReady1}, 32'd1);
    chk("bp_valid_after", {31'd0, LoadValid1}, 32'd0);
    drain1();

    // back-to-back with ready tied high: one result every 4 cycles
    issue1(3'b010, 10'h008, 32'h12345678, 1'b0, a0);
    issue1(3'b000, 10'h009, 32'h00000056, 1'b0, a1);
    issue1(3'b101, 10'h00A, 32'h00001234, 1'b0, a2);
    chk("b2b_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_gap2", 32'(a2 - a1), 32'd4);
    drain1();

    // instance B: latency READ_LATENCY+2 = 5
    issue3(3'b010, 10'h008, lat, d, f);
    chk("l3_lw_lat", 32'(lat), 32'd5);
    chk("l3_lw_data", d, 32'h12345678);
    chk("l3_lw_fault", {31'd0, f}, 32'd0);

    // reset while in WAIT
    nv = 0;
    while (ReqReady3 !== 1'b1 && nv < 20) begin tick(); nv++; end
    Instr3 = {17'd0, 3'b000, 5'd1, 7'b0000011};
    Addr3  = 10'h00D;
    LoadReq3 = 1'b1;
    tick();                 // READ
    LoadReq3 = 1'b0;
    tick();                 // WAIT
    rstn3 = 1'b0;
    tick();
    chk("abort_reqready", {31'd0, ReqReady3}, 32'd1);
    chk("abort_rden", {31'd0, MemRdEn3}, 32'd0);
    chk("abort_rdaddr", {24'd0, MemRdAddr3}, 32'd0);
    chk("abort_data", LoadData3, 32'd0);
    chk("abort_fault", {31'd0, LoadFault3}, 32'd0);
    chk("abort_valid", {31'd0, LoadValid3}, 32'd0);
    rstn3 = 1'b1;
    nv = 0;
    repeat (8) begin
      tick();
      if (LoadValid3 === 1'b1) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);

    issue3(3'b010, 10'h004, lat, d, f);
    chk("post_rst_lat", 32'(lat), 32'd5);
    chk("post_rst_data", d, 32'h8001ABCD);
    issue3(3'b001, 10'h001, lat, d, f);
    chk("l3_fault_lat", 32'(lat), 32'd1);
    chk("l3_fault_data", d, 32'd0);
    chk("l3_fault_flag", {31'd0, f}, 32'd1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
